// File: rtl/sdram_port_arb.sv
// Arbitrates N toggle-handshake clients onto one toggle-handshake SDRAM controller port.
// Define SDRAM_ARB_RR_EN for round-robin selection; otherwise fixed priority (lowest index wins).
module sdram_port_arb #(
  parameter int N  = 4,
  parameter int AW = 23,
  parameter int DW = 16,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            init_n,
  input  logic [N-1:0]    c_req,
  output logic [N-1:0]    c_ack,
  input  logic [N-1:0]    c_we,
  input  logic [N*AW-1:0] c_addr,
  input  logic [2*N-1:0]  c_ds,
  input  logic [N*DW-1:0] c_d,
  output logic [N*DW-1:0] c_q,
  output logic            mem_req,
  input  logic            mem_ack,
  output logic            mem_we,
  output logic [AW-1:0]   mem_a,
  output logic [1:0]      mem_ds,
  output logic [DW-1:0]   mem_d,
  input  logic [DW-1:0]   mem_q,
  output logic [IW-1:0]   grant,
  output logic            busy
);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e          state_q;
  logic [N-1:0]    c_ack_q;
  logic [N*DW-1:0] c_q_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [AW-1:0]   mem_a_q;
  logic [1:0]      mem_ds_q;
  logic [DW-1:0]   mem_d_q;
  logic [IW-1:0]   grant_q;
  logic            busy_q;
  logic [IW-1:0]   rr_q;

  logic [N-1:0]    pend;
  logic            any_pend;
  logic            done;
  logic [IW-1:0]   win_d;
  logic [IW-1:0]   rr_d;

  assign pend     = c_req ^ c_ack_q;
  assign any_pend = |pend;
  assign done     = (mem_ack == mem_req_q);
  assign rr_d     = (grant_q == IW'(N - 1)) ? '0 : grant_q + 1'b1;

  // Descending scan so the candidate closest to the search start is written last and wins.
  always_comb begin
    win_d = '0;
`ifdef SDRAM_ARB_RR_EN
    for (int k = N - 1; k >= 0; k--) begin
      if (int'(rr_q) + k < N) begin
        if (pend[int'(rr_q) + k]) win_d = IW'(int'(rr_q) + k);
      end else if (pend[int'(rr_q) + k - N]) begin
        win_d = IW'(int'(rr_q) + k - N);
      end
    end
`else
    for (int k = N - 1; k >= 0; k--) begin
      if (pend[k]) win_d = IW'(k);
    end
`endif
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q   <= IDLE;
      c_ack_q   <= '0;
      c_q_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_a_q   <= '0;
      mem_ds_q  <= '0;
      mem_d_q   <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      rr_q      <= '0;
    end else begin
      rr_q <= (state_q == WAIT && done) ? rr_d : rr_q;
      case (state_q)
        IDLE: begin
          if (any_pend) begin
            mem_we_q  <= c_we[win_d];
            mem_a_q   <= c_addr[win_d*AW +: AW];
            mem_ds_q  <= c_ds[win_d*2 +: 2];
            mem_d_q   <= c_d[win_d*DW +: DW];
            mem_req_q <= ~mem_req_q;
            grant_q   <= win_d;
            busy_q    <= 1'b1;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          // Completion returns to IDLE only, so a new issue needs at least one more edge.
          if (done) begin
            if (!mem_we_q) c_q_q[grant_q*DW +: DW] <= mem_q;
            c_ack_q[grant_q] <= c_req[grant_q];
            busy_q           <= 1'b0;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign c_ack   = c_ack_q;
  assign c_q     = c_q_q;
  assign mem_req = mem_req_q;
  assign mem_we  = mem_we_q;
  assign mem_a   = mem_a_q;
  assign mem_ds  = mem_ds_q;
  assign mem_d   = mem_d_q;
  assign grant   = grant_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: directed scenarios plus a randomized run against a transaction-level model.
module tb_sdram_port_arb;
  localparam int N  = 4;
  localparam int AW = 23;
  localparam int DW = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            init_n;
  logic [N-1:0]    c_req, c_ack, c_we;
  logic [N*AW-1:0] c_addr;
  logic [2*N-1:0]  c_ds;
  logic [N*DW-1:0] c_d, c_q;
  logic            mem_req, mem_ack, mem_we;
  logic [AW-1:0]   mem_a;
  logic [1:0]      mem_ds;
  logic [DW-1:0]   mem_d, mem_q;
  logic [IW-1:0]   grant;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_port_arb #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .init_n(init_n),
    .c_req(c_req), .c_ack(c_ack), .c_we(c_we), .c_addr(c_addr), .c_ds(c_ds), .c_d(c_d), .c_q(c_q),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we), .mem_a(mem_a), .mem_ds(mem_ds),
    .mem_d(mem_d), .mem_q(mem_q), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] d, logic [1:0] ds);
    return {ds[1] ? d[15:8] : old[15:8], ds[0] ? d[7:0] : old[7:0]};
  endfunction

  function automatic logic [15:0] dflt(logic [AW-1:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  // Controller stand-in: acknowledges after a programmable latency, stores byte-merged writes.
  logic [DW-1:0] ctrl_mem [int];
  int lat_fix  = 0;
  bit lat_rand = 1'b0;
  int rlat, cnt_c;

  function automatic logic [DW-1:0] ctrl_rd(logic [AW-1:0] a);
    return ctrl_mem.exists(int'(a)) ? ctrl_mem[int'(a)] : dflt(a);
  endfunction

  always @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      mem_ack <= 1'b0;
      mem_q   <= '0;
      cnt_c   <= 0;
      rlat    <= 0;
    end else if (mem_req != mem_ack) begin
      if (cnt_c >= (lat_rand ? rlat : lat_fix)) begin
        cnt_c   <= 0;
        mem_ack <= mem_req;
        rlat    <= $urandom_range(0, 5);
        if (mem_we) begin
          ctrl_mem[int'(mem_a)] = merge(ctrl_rd(mem_a), mem_d, mem_ds);
          mem_q <= DW'($urandom);
        end else begin
          mem_q <= ctrl_rd(mem_a);
        end
      end else begin
        cnt_c <= cnt_c + 1;
      end
    end
  end

  // Reference model: one outstanding transaction, winner chosen from the pending set.
  logic [DW-1:0]   exp_mem [int];
  logic [N-1:0]    m_ack;
  logic [N*DW-1:0] m_cq;
  bit              m_busy;
  logic            m_req, m_we, ack_s;
  logic [AW-1:0]   m_a;
  logic [1:0]      m_ds;
  logic [DW-1:0]   m_d;
  int              m_w, m_rr, m_grant;

  function automatic logic [DW-1:0] exp_rd(logic [AW-1:0] a);
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : dflt(a);
  endfunction

  function automatic int pick(logic [N-1:0] p);
`ifdef SDRAM_ARB_RR_EN
    for (int k = 0; k < N; k++) if (p[(m_rr + k) % N]) return (m_rr + k) % N;
`else
    for (int k = 0; k < N; k++) if (p[k]) return k;
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_ack = '0; m_cq = '0; m_busy = 1'b0; m_req = 1'b0; m_we = 1'b0; ack_s = 1'b0;
    m_a = '0; m_ds = '0; m_d = '0; m_w = 0; m_rr = 0; m_grant = 0;
  endtask

  task automatic cycle();
    logic [N-1:0] pend;
    @(posedge clk); #1;
    pend = c_req ^ m_ack;
    if (!m_busy) begin
      if (pend != '0) begin
        m_w = pick(pend); m_busy = 1'b1; m_req = ~m_req; m_grant = m_w;
        m_we = c_we[m_w]; m_a = c_addr[m_w*AW +: AW]; m_ds = c_ds[m_w*2 +: 2]; m_d = c_d[m_w*DW +: DW];
      end
    end else if (ack_s == m_req) begin
      if (!m_we) m_cq[m_w*DW +: DW] = exp_rd(m_a);
      else exp_mem[int'(m_a)] = merge(exp_rd(m_a), m_d, m_ds);
      m_ack[m_w] = c_req[m_w]; m_busy = 1'b0; m_rr = (m_w + 1) % N;
    end
    ack_s = mem_ack;
  endtask

  task automatic set_client(int i, logic we, logic [AW-1:0] a, logic [1:0] ds, logic [DW-1:0] d);
    c_we[i] = we; c_addr[i*AW +: AW] = a; c_ds[i*2 +: 2] = ds; c_d[i*DW +: DW] = d;
    c_req[i] = ~c_req[i];
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    init_n = 1'b0; c_req = '0; c_we = '0; c_addr = '0; c_ds = '0; c_d = '0;
    model_reset();
    @(posedge clk); #1;
    init_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    init_n = 1'b0;
    #1;
    n_tests++; if (c_ack !== '0 || c_q !== '0) begin n_fail++; $display("FAIL reset_client: ack=%h q=%h required 0", c_ack, c_q); end
    n_tests++; if ({mem_req, mem_we, mem_ds} !== 4'b0 || mem_a !== '0 || mem_d !== '0) begin n_fail++;
      $display("FAIL reset_mem: req=%b we=%b a=%h ds=%b d=%h required 0", mem_req, mem_we, mem_a, mem_ds, mem_d); end
    n_tests++; if (grant !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_grant: grant=%0d busy=%b required 0", grant, busy); end
    model_reset();
    @(posedge clk); #1;
    init_n = 1'b1;
  endtask

  task automatic test_single_read();
    logic prev; int n;
    lat_rand = 1'b0; lat_fix = 4;
    ctrl_mem[32'h1234] = 16'hBEEF; exp_mem[32'h1234] = 16'hBEEF;
    prev = mem_req;
    set_client(2, 1'b0, 23'h001234, 2'b11, 16'h0000);
    cycle();
    n_tests++; if (mem_req !== ~prev) begin n_fail++; $display("FAIL rd_issue: mem_req=%b required %b", mem_req, ~prev); end
    n_tests++; if (mem_a !== 23'h001234 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_bus: a=%h we=%b required 001234/0", mem_a, mem_we); end
    n_tests++; if (grant !== 2'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL rd_grant: grant=%0d busy=%b required 2/1", grant, busy); end
    n = 0;
    while (c_ack[2] !== c_req[2] && n < 30) begin cycle(); n++; end
    n_tests++; if (n != 6) begin n_fail++; $display("FAIL rd_latency: %0d cycles required 6", n); end
    n_tests++; if (c_q[2*DW +: DW] !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: c_q[2]=%h required beef", c_q[2*DW +: DW]); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy: busy=%b required 0", busy); end
  endtask

  task automatic test_write();
    logic [DW-1:0] q0; int n;
    lat_rand = 1'b0; lat_fix = 2;
    q0 = c_q[DW-1:0];
    set_client(0, 1'b1, 23'h000042, 2'b01, 16'h00A5);
    cycle();
    n_tests++; if (mem_we !== 1'b1 || mem_ds !== 2'b01 || mem_d !== 16'h00A5 || mem_a !== 23'h000042) begin n_fail++;
      $display("FAIL wr_bus: we=%b ds=%b d=%h a=%h required 1/01/00a5/000042", mem_we, mem_ds, mem_d, mem_a); end
    n = 0;
    while (c_ack[0] !== c_req[0] && n < 30) begin cycle(); n++; end
    n_tests++; if (n >= 30) begin n_fail++; $display("FAIL wr_timeout: no ack after %0d cycles", n); end
    n_tests++; if (c_q[DW-1:0] !== q0) begin n_fail++; $display("FAIL wr_cq: c_q[0]=%h required %h", c_q[DW-1:0], q0); end
    n_tests++; if (mem_d !== 16'h00A5 || mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_hold: d=%h we=%b required 00a5/1", mem_d, mem_we); end
    set_client(0, 1'b0, 23'h000042, 2'b11, 16'h0000);
    n = 0;
    do begin cycle(); n++; end while (c_ack[0] !== c_req[0] && n < 30);
    n_tests++; if (c_q[DW-1:0] !== 16'hC3A5) begin n_fail++; $display("FAIL wr_readback: c_q[0]=%h required c3a5", c_q[DW-1:0]); end
  endtask

  task automatic test_back_to_back();
    logic p0; int n;
    lat_rand = 1'b0; lat_fix = 1;
    set_client(1, 1'b0, 23'h000300, 2'b11, 16'h0000);
    n = 0;
    do begin cycle(); n++; end while (c_ack[1] !== c_req[1] && n < 30);
    n_tests++; if (n >= 30) begin n_fail++; $display("FAIL b2b_timeout: no ack after %0d cycles", n); end
    p0 = mem_req;
    cycle();
    set_client(1, 1'b0, 23'h000301, 2'b11, 16'h0000);
    n_tests++; if (mem_req !== p0) begin n_fail++; $display("FAIL b2b_early: mem_req=%b required %b", mem_req, p0); end
    cycle();
    n_tests++; if (mem_req !== ~p0 || grant !== 2'd1 || mem_a !== 23'h000301) begin n_fail++;
      $display("FAIL b2b_issue: req=%b grant=%0d a=%h required %b/1/000301", mem_req, grant, mem_a, ~p0); end
    n = 0;
    while (c_ack[1] !== c_req[1] && n < 30) begin cycle(); n++; end
    n_tests++; if (c_q[DW +: DW] !== 16'hC0A4) begin n_fail++; $display("FAIL b2b_data: c_q[1]=%h required c0a4", c_q[DW +: DW]); end
  endtask

  task automatic test_arbitration();
    int seq[$]; int exp_seq[4]; logic prev; bit retog; int n;
`ifdef SDRAM_ARB_RR_EN
    exp_seq = '{0, 1, 3, 0};
`else
    exp_seq = '{0, 0, 1, 3};
`endif
    do_reset();
    lat_rand = 1'b0; lat_fix = 2; retog = 1'b0; n = 0;
    set_client(0, 1'b0, 23'h000200, 2'b11, 16'h0);
    set_client(1, 1'b0, 23'h000201, 2'b11, 16'h0);
    set_client(3, 1'b0, 23'h000203, 2'b11, 16'h0);
    while (seq.size() < 4 && n < 200) begin
      prev = mem_req; cycle(); n++;
      if (mem_req !== prev) seq.push_back(int'(grant));
      if (!retog && c_ack[0] === c_req[0]) begin c_req[0] = ~c_req[0]; retog = 1'b1; end
    end
    n_tests++; if (seq.size() != 4) begin n_fail++; $display("FAIL arb_timeout: %0d issues seen required 4", seq.size()); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= seq.size()) begin n_fail++; $display("FAIL arb_order[%0d]: missing required %0d", i, exp_seq[i]); end
      else if (seq[i] != exp_seq[i]) begin n_fail++; $display("FAIL arb_order[%0d]: grant=%0d required %0d", i, seq[i], exp_seq[i]); end
    end
  endtask

  task automatic test_starvation();
    int seq[$]; int exp_seq[8]; logic prev; int n;
`ifdef SDRAM_ARB_RR_EN
    exp_seq = '{0, 3, 0, 3, 0, 3, 0, 3};
`else
    exp_seq = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
    do_reset();
    lat_rand = 1'b0; lat_fix = 1; n = 0;
    set_client(0, 1'b0, 23'h000210, 2'b11, 16'h0);
    set_client(3, 1'b0, 23'h000213, 2'b11, 16'h0);
    while (seq.size() < 8 && n < 300) begin
      prev = mem_req; cycle(); n++;
      if (mem_req !== prev) seq.push_back(int'(grant));
      if (seq.size() < 8) begin
        if (c_ack[0] === c_req[0]) c_req[0] = ~c_req[0];
        if (c_ack[3] === c_req[3]) c_req[3] = ~c_req[3];
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (i >= seq.size()) begin n_fail++; $display("FAIL starve_order[%0d]: missing required %0d", i, exp_seq[i]); end
      else if (seq[i] != exp_seq[i]) begin n_fail++; $display("FAIL starve_order[%0d]: grant=%0d required %0d", i, seq[i], exp_seq[i]); end
    end
    n = 0;
    while (c_ack[3] !== c_req[3] && n < 100) begin cycle(); n++; end
    n_tests++; if (c_ack[3] !== c_req[3]) begin n_fail++; $display("FAIL starve_drop: c_ack[3]=%b required %b", c_ack[3], c_req[3]); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    lat_rand = 1'b0; lat_fix = 10;
    set_client(1, 1'b0, 23'h000305, 2'b11, 16'h0);
    repeat (3) cycle();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: busy=%b required 1", busy); end
    init_n = 1'b0;
    #1;
    n_tests++; if (c_ack !== '0 || c_q !== '0 || grant !== '0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL mid_client: ack=%h q=%h grant=%0d busy=%b required 0", c_ack, c_q, grant, busy); end
    n_tests++; if ({mem_req, mem_we, mem_ds} !== 4'b0 || mem_a !== '0 || mem_d !== '0) begin n_fail++;
      $display("FAIL mid_mem: req=%b we=%b a=%h ds=%b d=%h required 0", mem_req, mem_we, mem_a, mem_ds, mem_d); end
    model_reset();
    @(posedge clk); #1;
    n_tests++; if (c_ack !== '0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_hold: ack=%h req=%b required 0", c_ack, mem_req); end
    init_n = 1'b1;
    lat_fix = 2; n = 0;
    while (c_ack[1] !== c_req[1] && n < 50) begin cycle(); n++; end
    n_tests++; if (c_ack[1] !== c_req[1] || c_q[DW +: DW] !== 16'hC0A0) begin n_fail++;
      $display("FAIL mid_restart: ack=%b q=%h required %b/c0a0", c_ack[1], c_q[DW +: DW], c_req[1]); end
  endtask

  task automatic test_random();
    int n;
    do_reset();
    lat_rand = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      cycle();
      n_tests++; if (c_ack !== m_ack || busy !== m_busy || mem_req !== m_req) begin n_fail++;
        $display("FAIL rnd_ctrl@%0d: ack=%h busy=%b req=%b required %h/%b/%b", cyc, c_ack, busy, mem_req, m_ack, m_busy, m_req); end
      n_tests++; if (int'(grant) != m_grant || mem_we !== m_we || mem_a !== m_a || mem_ds !== m_ds || mem_d !== m_d) begin n_fail++;
        $display("FAIL rnd_bus@%0d: g=%0d we=%b a=%h ds=%b d=%h required %0d/%b/%h/%b/%h",
                 cyc, grant, mem_we, mem_a, mem_ds, mem_d, m_grant, m_we, m_a, m_ds, m_d); end
      n_tests++; if (c_q !== m_cq) begin n_fail++; $display("FAIL rnd_data@%0d: c_q=%h required %h", cyc, c_q, m_cq); end
      if (cyc < 700) begin
        for (int i = 0; i < N; i++) begin
          if (c_req[i] === m_ack[i] && $urandom_range(0, 3) == 0)
            set_client(i, 1'($urandom_range(0, 1)), AW'(32'h100 + $urandom_range(0, 15)),
                       2'($urandom_range(1, 3)), DW'($urandom));
        end
      end
    end
    n = 0;
    while ((m_busy || c_req !== m_ack) && n < 200) begin cycle(); n++; end
    n_tests++; if (c_ack !== c_req || c_q !== m_cq) begin n_fail++;
      $display("FAIL rnd_drain: ack=%h q=%h required %h/%h", c_ack, c_q, c_req, m_cq); end
  endtask

  initial begin
    init_n = 1'b1; c_req = '0; c_we = '0; c_addr = '0; c_ds = '0; c_d = '0;
    model_reset();
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_arbitration();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
